high_bit_search_seq: RTL and testbench
======================================

# high_bit_search_seq

Parametrised, handshaked successor to the single-cycle high-bit search. It accepts one `INPUT_WIDTH`-bit word per transaction and returns the index of its most significant set bit. The index is found by a registered binary search, one halving step per clock, with an explicit flag for an all-zero word. The block sits between any valid/ready producer and consumer in the datapath.

## Interface
- `INPUT_WIDTH`, default 8: width of the searched word; power of two, ≥ 2.
- `RESULT_WIDTH`, localparam `$clog2(INPUT_WIDTH)`: width of the index; also the number of search steps, R.
- `clk`  input  1: single clock; all logic on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: `in_data` is presented.
- `in_ready`  output  1: block can accept a word.
- `in_data`  input  `INPUT_WIDTH`: word to search.
- `out_valid`  output  1: result is presented.
- `out_ready`  input  1: consumer takes the result.
- `out_index`  output  `RESULT_WIDTH`: bit index of the found set bit.
- `out_zero`  output  1: the accepted word was all zeros.
- `in_mode`  input  1: present only with `HBS_LOW_BIT_EN`; see Configuration.

## Operation
- The FSM has three states:
  - `IDLE`: `in_ready`=1.
  - `SEARCH`: R steps.
  - `DONE`: `out_valid`=1.
- **Accept:** in `IDLE`, `in_valid`=1 captures the word.
  - Registers load as `data` ← `in_data`, `size` ← `INPUT_WIDTH/2`, `acc` ← 0, `zero` ← (`in_data`==0).
  - The FSM goes to `SEARCH`.
- **SEARCH step**, once per cycle:
  - Compute `half` = upper `size` bits of the active `2*size`-bit window of `data`.
  - If `half`≠0: `data` ← `half`, `acc` ← `acc` + `size`. Otherwise `data` keeps its low `size` bits.
  - Then `size` ← `size`>>1.
  - The step taken with `size`==1 is the last one; the FSM then goes to `DONE`.
- `acc` is `RESULT_WIDTH` bits wide and cannot overflow, because the step sizes sum to `INPUT_WIDTH`−1.
- **DONE:** `out_index`=`acc` and `out_zero`=`zero`. Both are held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`=1 the FSM returns to `IDLE`.
- **Zero word:** the full R steps are still executed, giving fixed latency. Result is `out_index`=0, `out_zero`=1.
- **No overlap:** `in_ready`=0 in `SEARCH` and `DONE`. `in_valid` in those states is ignored and the word is not consumed.
- `in_data` is sampled only on the accepting edge. Later changes to it do not affect the search in progress.

## Timing
- **Reset values:** state `IDLE`. `in_ready`=1, `out_valid`=0, `out_index`=0, `out_zero`=0, internal registers 0.
- **Reset mid-operation:** `rst` in any state returns to `IDLE` on that edge. The in-flight word is discarded and no `out_valid` is produced for it.
- **Latency:** `out_valid` rises R+1 edges after the accepting edge: R `SEARCH` edges plus the transition edge. For W=8 that is 4 edges; for W=32 it is 6.
- **Throughput:** at most one word per R+2 cycles, reached when `out_ready` is held at 1.
- **Back-pressure:** `DONE` persists indefinitely while `out_ready`=0. The output handshake completes on the edge where `out_valid`&`out_ready`.
- **In-ready timing:** `in_ready` is high on the cycle after the output handshake. It is never high in the same cycle as `out_valid`.
- **Single-bit case:** W=2 gives R=1, so exactly one `SEARCH` step.

## Configuration
- **`HBS_LOW_BIT_EN` defined:**
  - Port `in_mode` exists and is sampled with `in_data` on accept.
  - `in_mode`=0: highest set bit, exactly as above.
  - `in_mode`=1: lowest set bit. The word is bit-reversed on capture and the reported index is `INPUT_WIDTH`−1−`acc`.
  - In both modes, latency, handshake and zero handling are unchanged. A zero word still gives `out_index`=0, `out_zero`=1.
- **`HBS_LOW_BIT_EN` undefined:** `in_mode` is absent, and the block performs highest-set-bit search only.

## Test plan
- **Single-bit ends:** W=8, accept 0x01 → `out_index`=0, `out_zero`=0; then 0x80 → 7. `out_valid` rises 4 edges after each accept.
- **Mixed word:** accept 0x5A → `out_index`=6. With W=32, accept 0x0001_0000 → 16, `out_valid` after 6 edges.
- **Zero and ignored input:** accept 0x00 → `out_index`=0, `out_zero`=1, same 4-edge latency. `in_valid` held high throughout shows `in_ready`=0 and no second word consumed during `SEARCH`/`DONE`.
- **Back-pressure:** `out_ready`=0 for 5 cycles after `out_valid` → `out_index`/`out_zero` stable, state held. `out_ready`=1 → `out_valid` drops next edge and `in_ready`=1.
- **Reset mid-search:** `rst` pulsed on the 2nd `SEARCH` cycle → next cycle `in_ready`=1, `out_valid`=0. A subsequent accept of 0x10 → 4 with normal latency.
- **`HBS_LOW_BIT_EN` build:** `in_mode`=1 with 0x58 → `out_index`=3. `in_mode`=0 with the same word → 6.

Source files
------------

// File: rtl/high_bit_search_seq.sv
// Handshaked most-significant-set-bit search: one binary-search halving step per clock.
// Optional HBS_LOW_BIT_EN adds in_mode to select lowest-set-bit search instead.
module high_bit_search_seq #(
   parameter  int INPUT_WIDTH  = 8,
   localparam int RESULT_WIDTH = $clog2(INPUT_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INPUT_WIDTH-1:0]  in_data,
`ifdef HBS_LOW_BIT_EN
   input  logic                    in_mode,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RESULT_WIDTH-1:0] out_index,
   output logic                    out_zero
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t                  state_q, state_d;
   logic [INPUT_WIDTH-1:0]  data_q, data_d;
   logic [RESULT_WIDTH-1:0] size_q, size_d;
   logic [RESULT_WIDTH-1:0] acc_q, acc_d;
   logic                    zero_q, zero_d;
   logic [INPUT_WIDTH-1:0]  cap_word;
   logic [INPUT_WIDTH-1:0]  low_mask;
   logic [INPUT_WIDTH-1:0]  half;
   logic [RESULT_WIDTH-1:0] result;
`ifdef HBS_LOW_BIT_EN
   logic                    mode_q, mode_d;
`endif

   always_comb begin
      cap_word = in_data;
`ifdef HBS_LOW_BIT_EN
      // Lowest-bit search is a highest-bit search on the mirrored word.
      if (in_mode) begin
         for (int i = 0; i < INPUT_WIDTH; i++) begin
            cap_word[i] = in_data[INPUT_WIDTH-1-i];
         end
      end
`endif
   end

   // data_q only ever holds the active 2*size window, so a shift yields the upper half.
   assign low_mask = ({{(INPUT_WIDTH-1){1'b0}}, 1'b1} << size_q) - {{(INPUT_WIDTH-1){1'b0}}, 1'b1};
   assign half     = (data_q >> size_q) & low_mask;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      size_d  = size_q;
      acc_d   = acc_q;
      zero_d  = zero_q;
`ifdef HBS_LOW_BIT_EN
      mode_d  = mode_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = cap_word;
               size_d  = RESULT_WIDTH'(INPUT_WIDTH / 2);
               acc_d   = '0;
               zero_d  = (in_data == '0);
`ifdef HBS_LOW_BIT_EN
               mode_d  = in_mode;
`endif
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (half != '0) begin
               data_d = half;
               acc_d  = acc_q + size_q;
            end else begin
               data_d = data_q & low_mask;
            end
            size_d = size_q >> 1;
            if (size_q == RESULT_WIDTH'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         size_q  <= '0;
         acc_q   <= '0;
         zero_q  <= 1'b0;
`ifdef HBS_LOW_BIT_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         size_q  <= size_d;
         acc_q   <= acc_d;
         zero_q  <= zero_d;
`ifdef HBS_LOW_BIT_EN
         mode_q  <= mode_d;
`endif
      end
   end

   always_comb begin
      result = acc_q;
`ifdef HBS_LOW_BIT_EN
      if (mode_q) begin
         result = RESULT_WIDTH'(INPUT_WIDTH - 1) - acc_q;
      end
`endif
      // An all-zero word reports index 0 in either search direction.
      if (zero_q) begin
         result = '0;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_index = out_valid ? result : '0;
   assign out_zero  = out_valid & zero_q;

endmodule

// File: tb/tb_high_bit_search_seq.sv
// Self-checking bench for high_bit_search_seq at widths 8, 32 and 2 against a bit-scan reference.
module tb_high_bit_search_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;

   logic        iv8 = 0, ir8, im8 = 0, ov8, or8 = 0, oz8;
   logic [7:0]  id8 = '0;
   logic [2:0]  oi8;
   logic        iv32 = 0, ir32, im32 = 0, ov32, or32 = 0, oz32;
   logic [31:0] id32 = '0;
   logic [4:0]  oi32;
   logic        iv2 = 0, ir2, im2 = 0, ov2, or2 = 0, oz2;
   logic [1:0]  id2 = '0;
   logic [0:0]  oi2;

`ifdef HBS_LOW_BIT_EN
   localparam bit LOW_EN = 1'b1;
`else
   localparam bit LOW_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   high_bit_search_seq #(.INPUT_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
`ifdef HBS_LOW_BIT_EN
      .in_mode(im8),
`endif
      .out_valid(ov8), .out_ready(or8), .out_index(oi8), .out_zero(oz8));

   high_bit_search_seq #(.INPUT_WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
`ifdef HBS_LOW_BIT_EN
      .in_mode(im32),
`endif
      .out_valid(ov32), .out_ready(or32), .out_index(oi32), .out_zero(oz32));

   high_bit_search_seq #(.INPUT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
`ifdef HBS_LOW_BIT_EN
      .in_mode(im2),
`endif
      .out_valid(ov2), .out_ready(or2), .out_index(oi2), .out_zero(oz2));

   // Reference: scan every bit; highest wins unless low mode, where the first found wins.
   function automatic int ref_idx(input logic [31:0] d, input int w, input bit low);
      int  r = 0;
      bit  found = 0;
      for (int i = 0; i < w; i++) begin
         if (d[i]) begin
            if (!low) r = i;
            else if (!found) begin
               r = i;
               found = 1;
            end
         end
      end
      return r;
   endfunction

   task automatic txn8(input logic [7:0] d, input bit m, input int bp, input bit keep_valid);
      int exp_i;
      bit exp_z;
      int lat;
      exp_i = ref_idx({24'h0, d}, 8, m);
      exp_z = (d == 8'h00);
      @(negedge clk);
      checks++;
      if (ir8 !== 1'b1) begin errors++; $display("FAIL accept_ready8 got %b want 1", ir8); end
      iv8 = 1; id8 = d; im8 = m; or8 = 0;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!keep_valid) iv8 = 0;
         id8 = 8'($urandom);
         im8 = LOW_EN ? 1'($urandom) : 1'b0;
         checks++;
         if (ir8 !== 1'b0) begin errors++; $display("FAIL busy_ready8 got %b want 0 at cycle %0d", ir8, lat); end
      end while (ov8 !== 1'b1 && lat < 20);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL latency8 got %0d want 4 (data %h)", lat, d); end
      checks++;
      if (oi8 !== 3'(exp_i) || oz8 !== exp_z) begin
         errors++;
         $display("FAIL result8 data %h mode %0d got idx %0d zero %b want idx %0d zero %b", d, m, oi8, oz8, exp_i, exp_z);
      end
      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         checks++;
         if (ov8 !== 1'b1 || ir8 !== 1'b0 || oi8 !== 3'(exp_i) || oz8 !== exp_z) begin
            errors++;
            $display("FAIL hold8 got valid %b ready %b idx %0d zero %b want 1 0 %0d %b", ov8, ir8, oi8, oz8, exp_i, exp_z);
         end
      end
      or8 = 1;
      @(negedge clk);
      or8 = 0; iv8 = 0;
      checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
         errors++;
         $display("FAIL release8 got valid %b ready %b want 0 1", ov8, ir8);
      end
   endtask

   task automatic txn32(input logic [31:0] d, input bit m);
      int exp_i;
      int lat;
      exp_i = ref_idx(d, 32, m);
      @(negedge clk);
      iv32 = 1; id32 = d; im32 = m; or32 = 1;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         iv32 = 0;
         id32 = $urandom;
      end while (ov32 !== 1'b1 && lat < 20);
      checks++;
      if (lat != 6) begin errors++; $display("FAIL latency32 got %0d want 6 (data %h)", lat, d); end
      checks++;
      if (oi32 !== 5'(exp_i) || oz32 !== (d == 0)) begin
         errors++;
         $display("FAIL result32 data %h mode %0d got idx %0d zero %b want idx %0d zero %b", d, m, oi32, oz32, exp_i, d == 0);
      end
      @(negedge clk);
      or32 = 0;
   endtask

   task automatic txn2(input logic [1:0] d, input bit m);
      int exp_i;
      int lat;
      exp_i = ref_idx({30'h0, d}, 2, m);
      @(negedge clk);
      iv2 = 1; id2 = d; im2 = m; or2 = 1;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         iv2 = 0;
      end while (ov2 !== 1'b1 && lat < 20);
      checks++;
      if (lat != 2) begin errors++; $display("FAIL latency2 got %0d want 2 (data %h)", lat, d); end
      checks++;
      if (oi2 !== 1'(exp_i) || oz2 !== (d == 0)) begin
         errors++;
         $display("FAIL result2 data %h mode %0d got idx %0d zero %b want idx %0d zero %b", d, m, oi2, oz2, exp_i, d == 0);
      end
      @(negedge clk);
      or2 = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (ir8 !== 1 || ov8 !== 0 || oi8 !== 0 || oz8 !== 0 || ir32 !== 1 || ov32 !== 0 || ir2 !== 1 || ov2 !== 0) begin
         errors++;
         $display("FAIL reset_state got ready %b valid %b idx %0d zero %b want 1 0 0 0", ir8, ov8, oi8, oz8);
      end
      rst = 0;
   endtask

   task automatic test_single_bit_ends();
      txn8(8'h01, 0, 0, 0);
      txn8(8'h80, 0, 0, 0);
   endtask

   task automatic test_mixed();
      txn8(8'h5A, 0, 0, 0);
      txn32(32'h0001_0000, 0);
   endtask

   task automatic test_zero();
      txn8(8'h00, 0, 2, 1);
      txn32(32'h0, 0);
   endtask

   task automatic test_back_pressure();
      txn8(8'h24, 0, 5, 0);
   endtask

   task automatic test_reset_mid();
      int bad;
      @(negedge clk);
      iv8 = 1; id8 = 8'hC3;
      @(posedge clk);
      @(negedge clk);
      iv8 = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got ready %b valid %b want 1 0", ir8, ov8);
      end
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (ov8 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reset_mid_discard got %0d valid cycles want 0", bad); end
      txn8(8'h10, 0, 0, 0);
   endtask

   task automatic test_low_bit();
      if (LOW_EN) begin
         txn8(8'h58, 1, 0, 0);
         txn8(8'h58, 0, 0, 0);
         txn8(8'h00, 1, 0, 0);
         txn32(32'h8000_0000, 1);
      end
   endtask

   task automatic test_single_bit_width();
      for (int v = 0; v < 4; v++) begin
         txn2(2'(v), 0);
         if (LOW_EN) txn2(2'(v), 1);
      end
   endtask

   task automatic test_random();
      logic [7:0]  d8;
      logic [31:0] d32;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       d8 = 8'h00;
            1:       d8 = 8'h01 << $urandom_range(0, 7);
            default: d8 = 8'($urandom);
         endcase
         txn8(d8, LOW_EN ? 1'($urandom) : 1'b0, $urandom_range(0, 3), 1'($urandom));
      end
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 3))
            0:       d32 = 32'h0;
            1:       d32 = 32'h1 << $urandom_range(0, 31);
            2:       d32 = $urandom >> $urandom_range(0, 31);
            default: d32 = $urandom;
         endcase
         txn32(d32, LOW_EN ? 1'($urandom) : 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_single_bit_ends();
      test_mixed();
      test_zero();
      test_back_pressure();
      test_reset_mid();
      test_low_bit();
      test_single_bit_width();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
